// File: rtl/trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states, trap kinds
// and mcause constants.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP_ENTER,
    ST_MRET_EXIT,
    ST_REDIRECT
  } state_t;

  // A sequence is either one of three trap causes or a return.
  typedef enum logic [1:0] {
    KIND_ECALL,
    KIND_TIMER,
    KIND_EXTERNAL,
    KIND_MRET
  } kind_t;

  localparam logic [31:0] CAUSE_ECALL_M    = 32'h0000_000B;
  localparam logic [31:0] CAUSE_TIMER_M    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXTERNAL_M = 32'h8000_000B;

  function automatic logic [31:0] cause_of(input kind_t kind);
    case (kind)
      KIND_TIMER:    return CAUSE_TIMER_M;
      KIND_EXTERNAL: return CAUSE_EXTERNAL_M;
      default:       return CAUSE_ECALL_M;
    endcase
  endfunction

endpackage

// File: rtl/trap_controller_sync.sv
// Two-flop synchronizer for the asynchronous timer/external interrupt request
// lines; bit 0 = timer, bit 1 = external.
module interrupt_synchronizer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] request,
  output logic [1:0] synced
);

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= request;
      sync_p1 <= sync_p0;
    end
  end

  assign synced = sync_p1;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: stall, drain memory, strobe CSRs,
// redirect fetch. Interrupts take part only when TRAP_CONTROLLER_INTERRUPT_EN is defined.
module trap_controller
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            execute_valid,
  input  logic [XLEN-1:0] execute_pc,
  input  logic            is_environment_call,
  input  logic            is_machine_return,
  input  logic            memory_busy,
  input  logic            timer_interrupt_request,
  input  logic            external_interrupt_request,
  input  logic            mstatus_mie,
  input  logic            mie_timer,
  input  logic            mie_external,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            pipeline_stall,
  output logic            pipeline_flush,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            trap_csr_write_enable,
  output logic [XLEN-1:0] trap_mepc_value,
  output logic [XLEN-1:0] trap_mcause_value,
  output logic            mret_csr_write_enable
);

  state_t          state, state_next;
  kind_t           kind_q, kind_next;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic            timer_pending;
  logic            external_pending;
  logic            detect;

  // The interrupt flag lives in the MSB of mcause regardless of XLEN.
  function automatic logic [XLEN-1:0] widen_cause(input logic [31:0] cause);
    logic [XLEN-1:0] value;
    value         = '0;
    value[30:0]   = cause[30:0];
    value[XLEN-1] = cause[31];
    return value;
  endfunction

`ifdef TRAP_CONTROLLER_INTERRUPT_EN
  logic [1:0] irq_synced;

  interrupt_synchronizer u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .request ({external_interrupt_request, timer_interrupt_request}),
    .synced  (irq_synced)
  );

  assign timer_pending    = irq_synced[0] & mie_timer & mstatus_mie;
  assign external_pending = irq_synced[1] & mie_external & mstatus_mie;
`else
  logic unused_irq;
  assign unused_irq       = ^{timer_interrupt_request, external_interrupt_request,
                              mstatus_mie, mie_timer, mie_external};
  assign timer_pending    = 1'b0;
  assign external_pending = 1'b0;
`endif

  // Direct-mode vector: the low mode bits of mtvec never reach the PC.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];

  assign detect = (state == ST_IDLE) && execute_valid &&
                  (external_pending || timer_pending ||
                   is_environment_call || is_machine_return);

  always_comb begin
    kind_next = kind_q;
    if (detect) begin
      if (external_pending)         kind_next = KIND_EXTERNAL;
      else if (timer_pending)       kind_next = KIND_TIMER;
      else if (is_environment_call) kind_next = KIND_ECALL;
      else                          kind_next = KIND_MRET;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (detect) state_next = ST_DRAIN;
      ST_DRAIN:      if (!memory_busy)
                       state_next = (kind_q == KIND_MRET) ? ST_MRET_EXIT : ST_TRAP_ENTER;
      ST_TRAP_ENTER: state_next = ST_REDIRECT;
      ST_MRET_EXIT:  state_next = ST_REDIRECT;
      ST_REDIRECT:   state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      kind_q   <= KIND_ECALL;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state  <= state_next;
      kind_q <= kind_next;
      if (detect) pc_q <= execute_pc;
      if (state == ST_TRAP_ENTER) target_q <= {mtvec[XLEN-1:2], 2'b00};
      if (state == ST_MRET_EXIT)  target_q <= mepc;
    end
  end

  // Everything but the detect-cycle stall is decoded from registered state.
  always_comb begin
    pipeline_stall        = 1'b0;
    pipeline_flush        = 1'b0;
    pc_redirect_valid     = 1'b0;
    pc_redirect_target    = '0;
    trap_csr_write_enable = 1'b0;
    trap_mepc_value       = '0;
    trap_mcause_value     = '0;
    mret_csr_write_enable = 1'b0;
    case (state)
      ST_IDLE:  pipeline_stall = detect;
      ST_DRAIN: pipeline_stall = 1'b1;
      ST_TRAP_ENTER: begin
        pipeline_stall        = 1'b1;
        trap_csr_write_enable = 1'b1;
        trap_mepc_value       = pc_q;
        trap_mcause_value     = widen_cause(cause_of(kind_q));
      end
      ST_MRET_EXIT: begin
        pipeline_stall        = 1'b1;
        mret_csr_write_enable = 1'b1;
      end
      ST_REDIRECT: begin
        pipeline_flush     = 1'b1;
        pc_redirect_valid  = 1'b1;
        pc_redirect_target = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller; interrupt scenarios follow
// the TRAP_CONTROLLER_INTERRUPT_EN build setting.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        execute_valid;
  logic [31:0] execute_pc;
  logic        is_environment_call;
  logic        is_machine_return;
  logic        memory_busy;
  logic        timer_interrupt_request;
  logic        external_interrupt_request;
  logic        mstatus_mie;
  logic        mie_timer;
  logic        mie_external;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        pipeline_stall;
  logic        pipeline_flush;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_target;
  logic        trap_csr_write_enable;
  logic [31:0] trap_mepc_value;
  logic [31:0] trap_mcause_value;
  logic        mret_csr_write_enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(32)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .execute_valid              (execute_valid),
    .execute_pc                 (execute_pc),
    .is_environment_call        (is_environment_call),
    .is_machine_return          (is_machine_return),
    .memory_busy                (memory_busy),
    .timer_interrupt_request    (timer_interrupt_request),
    .external_interrupt_request (external_interrupt_request),
    .mstatus_mie                (mstatus_mie),
    .mie_timer                  (mie_timer),
    .mie_external               (mie_external),
    .mtvec                      (mtvec),
    .mepc                       (mepc),
    .pipeline_stall             (pipeline_stall),
    .pipeline_flush             (pipeline_flush),
    .pc_redirect_valid          (pc_redirect_valid),
    .pc_redirect_target         (pc_redirect_target),
    .trap_csr_write_enable      (trap_csr_write_enable),
    .trap_mepc_value            (trap_mepc_value),
    .trap_mcause_value          (trap_mcause_value),
    .mret_csr_write_enable      (mret_csr_write_enable)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Packs the 1-bit outputs {stall, flush, redirect, trap_we, mret_we}.
  function automatic logic [31:0] flags();
    return {27'd0, pipeline_stall, pipeline_flush, pc_redirect_valid,
            trap_csr_write_enable, mret_csr_write_enable};
  endfunction

  // Inputs are driven 1 time unit after a rising edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    execute_valid              = 1'b0;
    execute_pc                 = 32'h0;
    is_environment_call        = 1'b0;
    is_machine_return          = 1'b0;
    memory_busy                = 1'b0;
    timer_interrupt_request    = 1'b0;
    external_interrupt_request = 1'b0;
    mstatus_mie                = 1'b0;
    mie_timer                  = 1'b0;
    mie_external               = 1'b0;
  endtask

  initial begin
    clear_inputs();
    mtvec = 32'h2001;
    mepc  = 32'h104;
    rst_n = 1'b0;
    #1;
    check("reset_flags", flags(), 32'h0);
    check("reset_target", pc_redirect_target, 32'h0);
    check("reset_mcause", trap_mcause_value, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ECALL, no memory wait
    execute_valid = 1'b1; execute_pc = 32'h100; is_environment_call = 1'b1;
    #1 check("ecall_T_flags", flags(), 32'b10000);
    tick(); clear_inputs();
    #1 check("ecall_T1_flags", flags(), 32'b10000);
    tick();
    check("ecall_T2_flags", flags(), 32'b10010);
    check("ecall_T2_mepc", trap_mepc_value, 32'h100);
    check("ecall_T2_mcause", trap_mcause_value, 32'h0000000B);
    tick();
    check("ecall_T3_flags", flags(), 32'b01100);
    check("ecall_T3_target", pc_redirect_target, 32'h2000);
    tick();
    check("ecall_T4_idle", flags(), 32'h0);

    // ECALL with memory busy for three cycles after T
    execute_valid = 1'b1; execute_pc = 32'h100; is_environment_call = 1'b1;
    #1 check("busy_T_flags", flags(), 32'b10000);
    tick(); clear_inputs(); memory_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 check($sformatf("busy_T%0d_drain", i), flags(), 32'b10000);
      tick();
    end
    memory_busy = 1'b0;
    #1 check("busy_T4_drain", flags(), 32'b10000);
    tick();
    check("busy_T5_flags", flags(), 32'b10010);
    check("busy_T5_mepc", trap_mepc_value, 32'h100);
    tick();
    check("busy_T6_flags", flags(), 32'b01100);
    check("busy_T6_target", pc_redirect_target, 32'h2000);
    tick();

    // MRET
    execute_valid = 1'b1; execute_pc = 32'h2040; is_machine_return = 1'b1;
    #1 check("mret_T_flags", flags(), 32'b10000);
    tick(); clear_inputs();
    #1 check("mret_T1_flags", flags(), 32'b10000);
    tick();
    check("mret_T2_flags", flags(), 32'b10001);
    check("mret_T2_mcause", trap_mcause_value, 32'h0);
    tick();
    check("mret_T3_flags", flags(), 32'b01100);
    check("mret_T3_target", pc_redirect_target, 32'h104);
    tick();
    check("mret_T4_idle", flags(), 32'h0);

    // A bubble in EX never starts a sequence
    is_environment_call = 1'b1;
    #1 check("bubble_no_stall", flags(), 32'h0);
    tick(); clear_inputs();

`ifdef TRAP_CONTROLLER_INTERRUPT_EN
    // Timer interrupt becomes visible two edges after the request rises
    execute_valid = 1'b1; execute_pc = 32'h300;
    mstatus_mie = 1'b1; mie_timer = 1'b1; timer_interrupt_request = 1'b1;
    #1 check("timer_edge0", flags(), 32'h0);
    tick();
    check("timer_edge1", flags(), 32'h0);
    tick();
    check("timer_T_flags", flags(), 32'b10000);
    tick(); clear_inputs();
    #1 check("timer_T1_flags", flags(), 32'b10000);
    tick();
    check("timer_T2_flags", flags(), 32'b10010);
    check("timer_T2_mcause", trap_mcause_value, 32'h80000007);
    check("timer_T2_mepc", trap_mepc_value, 32'h300);
    tick();
    check("timer_T3_target", pc_redirect_target, 32'h2000);
    tick();
    check("timer_T4_idle", flags(), 32'h0);

    // Timer disabled in mie: never taken
    execute_valid = 1'b1; execute_pc = 32'h300;
    mstatus_mie = 1'b1; mie_timer = 1'b0; timer_interrupt_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("timer_masked_%0d", i), flags(), 32'h0);
    end
    clear_inputs();
    tick(); tick(); tick();

    // External, timer and ECALL together: external wins, single sequence
    mstatus_mie = 1'b1; mie_timer = 1'b1; mie_external = 1'b1;
    timer_interrupt_request = 1'b1; external_interrupt_request = 1'b1;
    tick(); tick();
    check("prio_pending_no_valid", flags(), 32'h0);
    execute_valid = 1'b1; execute_pc = 32'h400; is_environment_call = 1'b1;
    #1 check("prio_T_flags", flags(), 32'b10000);
    tick(); clear_inputs();
    tick();
    check("prio_T2_mcause", trap_mcause_value, 32'h8000000B);
    check("prio_T2_mepc", trap_mepc_value, 32'h400);
    tick();
    check("prio_T3_flags", flags(), 32'b01100);
    tick();
    check("prio_single_seq", flags(), 32'h0);
`else
    // Interrupts are inert in this build
    execute_valid = 1'b1; execute_pc = 32'h300;
    mstatus_mie = 1'b1; mie_timer = 1'b1; mie_external = 1'b1;
    timer_interrupt_request = 1'b1; external_interrupt_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("irq_ignored_%0d", i), flags(), 32'h0);
    end
    clear_inputs();
    tick();
`endif

    // Reset pulsed during DRAIN
    execute_valid = 1'b1; execute_pc = 32'h100; is_environment_call = 1'b1;
    tick(); clear_inputs(); memory_busy = 1'b1;
    #1 check("rst_pre_drain", flags(), 32'b10000);
    rst_n = 1'b0;
    #1 check("rst_mid_flags", flags(), 32'h0);
    tick();
    rst_n = 1'b1; memory_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_after_%0d", i), flags(), 32'h0);
    end
    check("rst_after_target", pc_redirect_target, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
